pill_drop_counter: RTL and testbench

//  Upstream counting stage of the bottle filler. Synchronises and debounces the raw pill-drop sensor, counts

---
 rtl/pill_drop_counter.sv | 197 +++++++++++++++++++
 tb/tb_pill_drop_counter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pill_drop_counter.sv
// Pill-drop counting stage: sensor sync/debounce, BCD pill and bottle counters, fill/swap/pause FSM.
// Optional feature: define SPILL_COUNT_EN to count pills that arrive while not filling.
module pill_drop_counter #(
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned SWAP_CYC     = 8
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       sensor_raw,
  input  logic       isWork,
  input  logic       conti,
  input  logic [3:0] maxL,
  input  logic [3:0] maxH,
  input  logic [3:0] botL,
  input  logic [3:0] botH,
  output logic [3:0] nowL,
  output logic [3:0] nowH,
  output logic [3:0] seqL,
  output logic [3:0] seqH,
  output logic       pill_pulse,
  output logic       bottle_done,
  output logic       allFull,
  output logic [7:0] spill_cnt
);

  localparam int unsigned DbW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned SwW = (SWAP_CYC > 1) ? $clog2(SWAP_CYC) : 1;

  typedef enum logic [2:0] {StIdle, StFill, StSwap, StPause, StDone} state_e;

  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] lo, hi;
    lo = v[3:0];
    hi = v[7:4];
    if (lo == 4'd9) begin
      lo = 4'd0;
      hi = (hi == 4'd9) ? 4'd0 : hi + 4'd1;
    end else begin
      lo = lo + 4'd1;
    end
    return {hi, lo};
  endfunction

  logic           sync1_q, sync2_q;
  logic           deb_q, deb_prev_q;
  logic [DbW-1:0] deb_cnt_q;
  logic           work_q;
  logic           pill_evt, work_rise, work_fall;

  state_e         state_q, state_d;
  logic [7:0]     now_q, now_d, seq_q, seq_d;
  logic [SwW-1:0] swap_cnt_q, swap_cnt_d;
  logic           done_d, pulse_q, done_q;
  logic [7:0]     max_bcd, bot_bcd, now_inc, seq_inc;

  // Debounce: the counter runs only while the synchronised level disagrees with the accepted one.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      deb_cnt_q  <= '0;
      work_q     <= 1'b0;
    end else begin
      sync1_q    <= sensor_raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      work_q     <= isWork;
      if (sync2_q != deb_q) begin
        if (deb_cnt_q == DbW'(DEBOUNCE_CYC - 1)) begin
          deb_q     <= sync2_q;
          deb_cnt_q <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_q + DbW'(1);
        end
      end else begin
        deb_cnt_q <= '0;
      end
    end
  end

  assign pill_evt  = deb_q & ~deb_prev_q;
  assign work_rise = isWork & ~work_q;
  assign work_fall = ~isWork & work_q;
  assign max_bcd   = {clamp9(maxH), clamp9(maxL)};
  assign bot_bcd   = {clamp9(botH), clamp9(botL)};
  assign now_inc   = bcd_inc(now_q);
  assign seq_inc   = bcd_inc(seq_q);

  always_comb begin
    state_d    = state_q;
    now_d      = now_q;
    seq_d      = seq_q;
    swap_cnt_d = swap_cnt_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (isWork && (max_bcd != 8'd0)) state_d = StFill;
      end
      StFill: begin
        if (pill_evt && isWork) begin
          // >= so a maximum lowered below the running count closes on the next pill.
          if (now_inc >= max_bcd) begin
            done_d     = 1'b1;
            seq_d      = seq_inc;
            now_d      = 8'd0;
            swap_cnt_d = '0;
            if ((bot_bcd != 8'd0) && (seq_inc == bot_bcd)) state_d = StDone;
            else if (conti)                                 state_d = StSwap;
            else                                            state_d = StPause;
          end else begin
            now_d = now_inc;
          end
        end
      end
      StSwap: begin
        if (swap_cnt_q == SwW'(SWAP_CYC - 1)) begin
          state_d = StFill;
          now_d   = 8'd0;
        end else begin
          swap_cnt_d = swap_cnt_q + SwW'(1);
        end
      end
      StPause: begin
        if (work_rise) begin
          state_d = StFill;
          now_d   = 8'd0;
        end
      end
      StDone: begin
        if (work_fall) begin
          state_d = StIdle;
          now_d   = 8'd0;
          seq_d   = 8'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= StIdle;
      now_q      <= 8'd0;
      seq_q      <= 8'd0;
      swap_cnt_q <= '0;
      pulse_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      now_q      <= now_d;
      seq_q      <= seq_d;
      swap_cnt_q <= swap_cnt_d;
      pulse_q    <= pill_evt;
      done_q     <= done_d;
    end
  end

  assign nowH        = now_q[7:4];
  assign nowL        = now_q[3:0];
  assign seqH        = seq_q[7:4];
  assign seqL        = seq_q[3:0];
  assign pill_pulse  = pulse_q;
  assign bottle_done = done_q;
  assign allFull     = (state_q == StDone);

`ifdef SPILL_COUNT_EN
  logic [7:0] spill_q, spill_d;
  logic       not_filling;

  assign not_filling = (state_q == StSwap) || (state_q == StPause) || (state_q == StDone);

  always_comb begin
    spill_d = spill_q;
    if ((state_q == StDone) && work_fall) begin
      spill_d = 8'd0;
    end else if (pill_evt && not_filling && (spill_q != 8'hFF)) begin
      spill_d = spill_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) spill_q <= 8'd0;
    else        spill_q <= spill_d;
  end

  assign spill_cnt = spill_q;
`else
  assign spill_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pill_drop_counter.sv
// Bench for pill_drop_counter: scenario table, hand-written corner sequences and random stimulus,
// all checked every cycle against an integer-level reference model.
module tb_pill_drop_counter;

  localparam int D  = 6;
  localparam int SW = 20;

  logic       CLK, RST_n, sensor_raw, isWork, conti;
  logic [3:0] maxL, maxH, botL, botH;
  logic [3:0] nowL, nowH, seqL, seqH;
  logic       pill_pulse, bottle_done, allFull;
  logic [7:0] spill_cnt;

  pill_drop_counter #(.DEBOUNCE_CYC(D), .SWAP_CYC(SW)) dut (
    .CLK(CLK), .RST_n(RST_n), .sensor_raw(sensor_raw), .isWork(isWork), .conti(conti),
    .maxL(maxL), .maxH(maxH), .botL(botL), .botH(botH),
    .nowL(nowL), .nowH(nowH), .seqL(seqL), .seqH(seqH),
    .pill_pulse(pill_pulse), .bottle_done(bottle_done), .allFull(allFull), .spill_cnt(spill_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Reference model: plain integers, sensor history as a queue of sampled raw levels.
  localparam int S_IDLE = 0, S_FILL = 1, S_SWAP = 2, S_PAUSE = 3, S_DONE = 4;
  int   m_st, m_now, m_seq, m_spill, m_timer;
  logic m_wprev, m_acc, m_evt_pend, e_pulse, e_done;
  logic hist[$];

  function automatic int clamp(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    logic [3:0] h, l;
    h = 4'(n / 10);
    l = 4'(n % 10);
    return {h, l};
  endfunction

  task automatic model_reset();
    m_st = S_IDLE; m_now = 0; m_seq = 0; m_spill = 0; m_timer = 0;
    m_wprev = 1'b0; m_acc = 1'b0; m_evt_pend = 1'b0; e_pulse = 1'b0; e_done = 1'b0;
    hist.delete();
    for (int i = 0; i < D + 2; i++) hist.push_back(1'b0);
  endtask

  task automatic spill_inc();
    if (m_spill < 255) m_spill++;
  endtask

  task automatic model_edge();
    logic ev, w, all_diff;
    int   n, mx, bt;
    ev = m_evt_pend;
    w  = (isWork === 1'b1);
    mx = clamp(maxH) * 10 + clamp(maxL);
    bt = clamp(botH) * 10 + clamp(botL);
    e_pulse = ev;
    e_done  = 1'b0;
    case (m_st)
      S_IDLE: if (w && mx != 0) m_st = S_FILL;
      S_FILL: begin
        if (ev && w) begin
          n = (m_now + 1) % 100;
          if (n >= mx) begin
            e_done  = 1'b1;
            m_seq   = (m_seq + 1) % 100;
            m_now   = 0;
            m_timer = 0;
            if (bt != 0 && m_seq == bt) m_st = S_DONE;
            else m_st = conti ? S_SWAP : S_PAUSE;
          end else begin
            m_now = n;
          end
        end
      end
      S_SWAP: begin
        if (ev) spill_inc();
        if (m_timer == SW - 1) begin
          m_st = S_FILL; m_now = 0;
        end else begin
          m_timer++;
        end
      end
      S_PAUSE: begin
        if (ev) spill_inc();
        if (w && !m_wprev) begin
          m_st = S_FILL; m_now = 0;
        end
      end
      default: begin
        if (ev) spill_inc();
        if (!w && m_wprev) begin
          m_st = S_IDLE; m_now = 0; m_seq = 0; m_spill = 0;
        end
      end
    endcase
    m_wprev = w;
    // Accepted level flips once the 2-cycle-delayed sensor has disagreed with it for D samples.
    hist.push_back(sensor_raw);
    while (hist.size() > D + 2) void'(hist.pop_front());
    all_diff = 1'b1;
    for (int k = 0; k < D; k++) if (hist[k] == m_acc) all_diff = 1'b0;
    m_evt_pend = 1'b0;
    if (all_diff) begin
      m_acc      = ~m_acc;
      m_evt_pend = m_acc;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_cycle();
    logic [7:0]  e_spill;
    logic [31:0] act, exp;
`ifdef SPILL_COUNT_EN
    e_spill = 8'(m_spill);
`else
    e_spill = 8'd0;
`endif
    act = {5'd0, nowH, nowL, seqH, seqL, pill_pulse, bottle_done, allFull, spill_cnt};
    exp = {5'd0, to_bcd(m_now), to_bcd(m_seq), e_pulse, e_done, (m_st == S_DONE), e_spill};
    check("cycle", act, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    if (RST_n) model_edge();
    #1;
    check_cycle();
  endtask

  task automatic do_reset();
    RST_n = 1'b0;
    model_reset();
    repeat (2) step();
    RST_n = 1'b1;
  endtask

  task automatic set_cfg(input logic [7:0] mx, input logic [7:0] bt, input logic c);
    {maxH, maxL} = mx;
    {botH, botL} = bt;
    conti = c;
  endtask

  task automatic pill(input int hi, input int lo);
    sensor_raw = 1'b1;
    repeat (hi) step();
    sensor_raw = 1'b0;
    repeat (lo) step();
  endtask

  task automatic clean_pills(input int n);
    for (int i = 0; i < n; i++) pill(D + 2, SW + D);
  endtask

  typedef struct {
    logic [7:0] maxv;
    logic [7:0] botv;
    logic       cont;
    int         pills;
    logic [7:0] exp_now;
    logic [7:0] exp_seq;
    logic       exp_full;
  } vec_t;

  vec_t vecs[7];
  int   pulses;
  logic [7:0] exp_sp;

  initial begin
    RST_n = 1'b0; sensor_raw = 1'b0; isWork = 1'b0; conti = 1'b0;
    maxL = 4'd0; maxH = 4'd0; botL = 4'd0; botH = 4'd0;
    model_reset();
    #2;
    check("reset_outputs", {5'd0, nowH, nowL, seqH, seqL, pill_pulse, bottle_done, allFull, spill_cnt},
          32'd0);

    vecs[0] = '{8'h03, 8'h02, 1'b1, 6,   8'h00, 8'h02, 1'b1};
    vecs[1] = '{8'h15, 8'h00, 1'b1, 10,  8'h10, 8'h00, 1'b0};
    vecs[2] = '{8'h15, 8'h00, 1'b1, 15,  8'h00, 8'h01, 1'b0};
    vecs[3] = '{8'h02, 8'h00, 1'b0, 3,   8'h00, 8'h01, 1'b0};
    vecs[4] = '{8'h01, 8'h00, 1'b1, 100, 8'h00, 8'h00, 1'b0};
    vecs[5] = '{8'h0F, 8'h01, 1'b1, 9,   8'h00, 8'h01, 1'b1};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 3,   8'h00, 8'h00, 1'b0};

    for (int v = 0; v < 7; v++) begin
      do_reset();
      set_cfg(vecs[v].maxv, vecs[v].botv, vecs[v].cont);
      isWork = 1'b1;
      repeat (2) step();
      clean_pills(vecs[v].pills);
      repeat (4) step();
      check("tbl_now", {24'd0, nowH, nowL}, {24'd0, vecs[v].exp_now});
      check("tbl_seq", {24'd0, seqH, seqL}, {24'd0, vecs[v].exp_seq});
      check("tbl_full", {31'd0, allFull}, {31'd0, vecs[v].exp_full});
    end

    // Bounce: 5 toggles in D-1 cycles, then a steady high.
    do_reset();
    set_cfg(8'h15, 8'h00, 1'b1);
    isWork = 1'b1;
    repeat (2) step();
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      sensor_raw = ~sensor_raw;
      step();
      if (pill_pulse) pulses++;
    end
    for (int i = 0; i < 2 * D + 8; i++) begin
      if (i == D + 4) sensor_raw = 1'b0;
      step();
      if (pill_pulse) pulses++;
    end
    check("bounce_pulses", 32'(pulses), 32'd1);
    check("bounce_now", {24'd0, nowH, nowL}, 32'h01);

    // Pause after a bottle, spill while paused, resume via isWork 1->0->1.
`ifdef SPILL_COUNT_EN
    exp_sp = 8'd1;
`else
    exp_sp = 8'd0;
`endif
    do_reset();
    set_cfg(8'h02, 8'h00, 1'b0);
    isWork = 1'b1;
    repeat (2) step();
    clean_pills(3);
    check("pause_spill", {24'd0, spill_cnt}, {24'd0, exp_sp});
    isWork = 1'b0;
    repeat (3) step();
    isWork = 1'b1;
    repeat (3) step();
    check("pause_resume_now", {24'd0, nowH, nowL}, 32'h00);
    clean_pills(1);
    check("pause_next_pill", {24'd0, nowH, nowL}, 32'h01);

    // Second pill lands inside SWAP and must not count.
    do_reset();
    set_cfg(8'h01, 8'h00, 1'b1);
    isWork = 1'b1;
    repeat (2) step();
    pill(D + 1, D + 1);
    pill(D + 1, SW + D);
    check("swap_seq", {24'd0, seqH, seqL}, 32'h01);
    check("swap_spill", {24'd0, spill_cnt}, {24'd0, exp_sp});
    clean_pills(1);
    check("swap_after_seq", {24'd0, seqH, seqL}, 32'h02);

    // DONE cleared by isWork falling.
    do_reset();
    set_cfg(8'h01, 8'h01, 1'b1);
    isWork = 1'b1;
    repeat (2) step();
    clean_pills(1);
    check("done_full", {31'd0, allFull}, 32'd1);
    isWork = 1'b0;
    repeat (2) step();
    check("done_clear", {23'd0, allFull, seqH, seqL}, 32'd0);

    // Asynchronous reset in the middle of a cycle while filling.
    do_reset();
    set_cfg(8'h15, 8'h00, 1'b1);
    isWork = 1'b1;
    repeat (2) step();
    clean_pills(7);
    check("prereset_now", {24'd0, nowH, nowL}, 32'h07);
    #2;
    RST_n = 1'b0;
    model_reset();
    #1;
    check("async_reset", {5'd0, nowH, nowL, seqH, seqL, pill_pulse, bottle_done, allFull, spill_cnt},
          32'd0);
    isWork = 1'b0;
    repeat (2) step();
    RST_n = 1'b1;
    repeat (3) step();
    check("post_reset_idle", {8'd0, nowH, nowL, seqH, seqL, 7'd0, allFull}, 32'd0);
    isWork = 1'b1;
    step();
    clean_pills(1);
    check("post_reset_pill", {24'd0, nowH, nowL}, 32'h01);

    // Random traffic: bouncy sensor, live config changes, isWork toggling.
    do_reset();
    isWork = 1'b1;
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 7) == 0) begin
        maxH = 4'($urandom_range(0, 1));
        maxL = 4'($urandom_range(0, 15));
        botH = 4'd0;
        botL = 4'($urandom_range(0, 4));
        conti = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 9) == 0) isWork = ~isWork;
      sensor_raw = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 3 * D)) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
